// File: rtl/fsm_control_multich.sv
// rtl/fsm_control_multich.sv - multi-channel FIFO control FSM with timed threshold latch
// INIT latches thresholds, then IDLE/ACTIVE/ERROR follow per-channel FIFO status.
module fsm_control_multich #(
   parameter int NUM_CH   = 4,
   parameter int MF_W     = 2,
   parameter int VC_W     = 4,
   parameter int D_W      = 2,
   parameter int INIT_CYC = 4,
   parameter int IDLE_DLY = 3
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       init,
   input  logic                       err_clear,
   input  logic [MF_W-1:0]            umbral_MF,
   input  logic [VC_W-1:0]            umbral_VC,
   input  logic [D_W-1:0]             umbral_D,
   input  logic [NUM_CH-1:0]          fifo_error,
   input  logic [NUM_CH-1:0]          fifo_empty,
   output logic [MF_W+VC_W+D_W-1:0]   umbrales_I,
   output logic                       umbrales_vld,
   output logic                       idle_out,
   output logic                       active_out,
   output logic                       error_out,
   output logic [NUM_CH-1:0]          error_ch,
   output logic [2:0]                 state_out
);

   localparam int MAX_CYC = (INIT_CYC > IDLE_DLY) ? INIT_CYC : IDLE_DLY;
   localparam int CW      = $clog2(MAX_CYC) + 1;
   localparam int UW      = MF_W + VC_W + D_W;
   localparam logic [CW-1:0] INIT_LAST = CW'(INIT_CYC - 1);
   localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_DLY - 1);

   typedef enum logic [2:0] {
      S_RESET  = 3'd0,
      S_INIT   = 3'd1,
      S_IDLE   = 3'd2,
      S_ACTIVE = 3'd3,
      S_ERROR  = 3'd4
   } state_t;

   state_t              state_q;
   logic [CW-1:0]       init_cnt_q;
   logic [CW-1:0]       idle_cnt_q;
   logic [UW-1:0]       umbrales_q;
   logic                vld_q;
   logic [NUM_CH-1:0]   error_ch_q;

   logic any_err;
   logic all_empty;

   assign any_err   = |fifo_error;
   assign all_empty = &fifo_empty;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= S_RESET;
         init_cnt_q <= '0;
         idle_cnt_q <= '0;
         umbrales_q <= '0;
         vld_q      <= 1'b0;
         error_ch_q <= '0;
      end else begin
         if (state_q inside {S_INIT, S_IDLE, S_ACTIVE})
            error_ch_q <= error_ch_q | fifo_error;

         case (state_q)
            S_RESET: begin
               vld_q <= 1'b0;
               if (init) begin
                  state_q    <= S_INIT;
                  init_cnt_q <= '0;
               end
            end
            S_INIT: begin
               // Sampled every INIT cycle; the last sample is what stays frozen.
               umbrales_q <= {umbral_MF, umbral_VC, umbral_D};
               init_cnt_q <= init_cnt_q + 1'b1;
               if (any_err) begin
                  state_q <= S_ERROR;
                  vld_q   <= 1'b0;
               end else if (init_cnt_q == INIT_LAST) begin
                  state_q <= S_IDLE;
                  vld_q   <= 1'b1;
               end
            end
            S_IDLE: begin
               if (any_err) begin
                  state_q <= S_ERROR;
                  vld_q   <= 1'b0;
               end else if (!all_empty) begin
                  state_q    <= S_ACTIVE;
                  idle_cnt_q <= '0;
               end
            end
            S_ACTIVE: begin
               if (any_err) begin
                  state_q <= S_ERROR;
                  vld_q   <= 1'b0;
               end else if (all_empty) begin
                  if (idle_cnt_q == IDLE_LAST)
                     state_q <= S_IDLE;
                  else
                     idle_cnt_q <= idle_cnt_q + 1'b1;
               end else begin
                  idle_cnt_q <= '0;
               end
            end
            S_ERROR: begin
               vld_q <= 1'b0;
               if (err_clear) begin
                  state_q    <= S_RESET;
                  error_ch_q <= '0;
               end
            end
            default: begin
               state_q <= S_RESET;
               vld_q   <= 1'b0;
            end
         endcase
      end
   end

   assign umbrales_I   = umbrales_q;
   assign umbrales_vld = vld_q;
   assign idle_out     = (state_q == S_IDLE);
   assign active_out   = (state_q == S_ACTIVE);
   assign error_out    = (state_q == S_ERROR);
   assign error_ch     = error_ch_q;
   assign state_out    = state_q;

endmodule

// File: tb/tb_fsm_control_multich.sv
// tb/tb_fsm_control_multich.sv - directed self-checking bench for fsm_control_multich
// A 4-channel instance is exercised fully; 8- and 1-channel builds share control inputs.
module tb_fsm_control_multich;

   logic       clk;
   logic       reset;
   logic       init;
   logic       err_clear;
   logic [1:0] umbral_MF;
   logic [3:0] umbral_VC;
   logic [1:0] umbral_D;

   logic [3:0] fifo_error;
   logic [3:0] fifo_empty;
   logic [7:0] umbrales_I;
   logic       umbrales_vld, idle_out, active_out, error_out;
   logic [3:0] error_ch;
   logic [2:0] state_out;

   logic [7:0] fifo_error8, fifo_empty8, error_ch8, umbrales_I8;
   logic       vld8, idle8, active8, error8;
   logic [2:0] state8;

   logic       fifo_error1, fifo_empty1, error_ch1;
   logic [7:0] umbrales_I1;
   logic       vld1, idle1, active1, error1;
   logic [2:0] state1;

   int n_checks = 0;
   int n_errors = 0;

   fsm_control_multich #(.NUM_CH(4)) u_dut (
      .clk(clk), .reset(reset), .init(init), .err_clear(err_clear),
      .umbral_MF(umbral_MF), .umbral_VC(umbral_VC), .umbral_D(umbral_D),
      .fifo_error(fifo_error), .fifo_empty(fifo_empty),
      .umbrales_I(umbrales_I), .umbrales_vld(umbrales_vld),
      .idle_out(idle_out), .active_out(active_out), .error_out(error_out),
      .error_ch(error_ch), .state_out(state_out)
   );

   fsm_control_multich #(.NUM_CH(8)) u_dut8 (
      .clk(clk), .reset(reset), .init(init), .err_clear(err_clear),
      .umbral_MF(umbral_MF), .umbral_VC(umbral_VC), .umbral_D(umbral_D),
      .fifo_error(fifo_error8), .fifo_empty(fifo_empty8),
      .umbrales_I(umbrales_I8), .umbrales_vld(vld8),
      .idle_out(idle8), .active_out(active8), .error_out(error8),
      .error_ch(error_ch8), .state_out(state8)
   );

   fsm_control_multich #(.NUM_CH(1)) u_dut1 (
      .clk(clk), .reset(reset), .init(init), .err_clear(err_clear),
      .umbral_MF(umbral_MF), .umbral_VC(umbral_VC), .umbral_D(umbral_D),
      .fifo_error(fifo_error1), .fifo_empty(fifo_empty1),
      .umbrales_I(umbrales_I1), .umbrales_vld(vld1),
      .idle_out(idle1), .active_out(active1), .error_out(error1),
      .error_ch(error_ch1), .state_out(state1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_n(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".state"},  {29'd0, state_out}, 32'd0);
      check({tag, ".flags"},  {28'd0, umbrales_vld, idle_out, active_out, error_out}, 32'd0);
      check({tag, ".umbr"},   {24'd0, umbrales_I}, 32'd0);
      check({tag, ".errch"},  {28'd0, error_ch}, 32'd0);
   endtask

   initial begin
      reset = 1'b0; init = 1'b0; err_clear = 1'b0;
      umbral_MF = 2'd0; umbral_VC = 4'd0; umbral_D = 2'd0;
      fifo_error = 4'h0; fifo_empty = 4'hF;
      fifo_error8 = 8'h00; fifo_empty8 = 8'hFF;
      fifo_error1 = 1'b0; fifo_empty1 = 1'b1;

      tick_n(2);
      check_all_zero("rst");

      // T1: timed INIT and threshold latch
      reset = 1'b1; init = 1'b1;
      umbral_MF = 2'd2; umbral_VC = 4'd9; umbral_D = 2'd1;
      tick();
      init = 1'b0;
      check("t1.init0", {29'd0, state_out}, 32'd1);
      for (int i = 1; i < 4; i++) begin
         tick();
         check("t1.init", {29'd0, state_out}, 32'd1);
         check("t1.vld_lo", {31'd0, umbrales_vld}, 32'd0);
      end
      tick();
      check("t1.idle", {29'd0, state_out}, 32'd2);
      check("t1.idle_out", {31'd0, idle_out}, 32'd1);
      check("t1.umbr", {24'd0, umbrales_I}, 32'hA5);
      check("t1.vld", {31'd0, umbrales_vld}, 32'd1);
      umbral_MF = 2'd1; umbral_VC = 4'd3; umbral_D = 2'd2;
      tick();
      check("t1.frozen", {24'd0, umbrales_I}, 32'hA5);
      check("t8.idle", {29'd0, state8}, 32'd2);
      check("t1b.idle", {29'd0, state1}, 32'd2);

      // T2: drain delay with restart
      fifo_empty = 4'b1011;
      tick();
      check("t2.active", {29'd0, state_out}, 32'd3);
      check("t2.active_out", {31'd0, active_out}, 32'd1);
      fifo_empty = 4'hF;
      tick_n(2);
      check("t2.drain2", {29'd0, state_out}, 32'd3);
      fifo_empty = 4'b1011;
      tick();
      check("t2.restart", {29'd0, state_out}, 32'd3);
      fifo_empty = 4'hF;
      tick_n(2);
      check("t2.drain2b", {29'd0, state_out}, 32'd3);
      tick();
      check("t2.back_idle", {29'd0, state_out}, 32'd2);

      // T3: error in ACTIVE, sticky ERROR
      fifo_empty = 4'b1011;
      tick();
      fifo_error = 4'b0100;
      tick();
      fifo_error = 4'h0; fifo_empty = 4'hF;
      check("t3.state", {29'd0, state_out}, 32'd4);
      check("t3.error_out", {31'd0, error_out}, 32'd1);
      check("t3.active_out", {31'd0, active_out}, 32'd0);
      check("t3.errch", {28'd0, error_ch}, 32'h4);
      check("t3.vld", {31'd0, umbrales_vld}, 32'd0);
      check("t3.umbr", {24'd0, umbrales_I}, 32'hA5);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("t3.hold", {29'd0, state_out}, 32'd4);
      end
      check("t3.errch_hold", {28'd0, error_ch}, 32'h4);

      // T4: software clear and re-latch
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;
      check("t4.reset", {29'd0, state_out}, 32'd0);
      check("t4.errch", {28'd0, error_ch}, 32'h0);
      umbral_MF = 2'd1; umbral_VC = 4'd6; umbral_D = 2'd3;
      init = 1'b1;
      tick();
      init = 1'b0;
      check("t4.init", {29'd0, state_out}, 32'd1);
      tick_n(3);
      check("t4.vld_lo", {31'd0, umbrales_vld}, 32'd0);
      tick();
      check("t4.idle", {29'd0, state_out}, 32'd2);
      check("t4.umbr", {24'd0, umbrales_I}, 32'h5B);
      check("t4.vld", {31'd0, umbrales_vld}, 32'd1);

      // T5a: error on last INIT cycle wins over INIT exit
      reset = 1'b0;
      tick();
      reset = 1'b1; init = 1'b1;
      tick();
      init = 1'b0;
      tick_n(3);
      check("t5.last_init", {29'd0, state_out}, 32'd1);
      fifo_error = 4'b0001;
      tick();
      fifo_error = 4'h0;
      check("t5.init_err", {29'd0, state_out}, 32'd4);
      check("t5.errch", {28'd0, error_ch}, 32'h1);
      check("t5.vld", {31'd0, umbrales_vld}, 32'd0);
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0; init = 1'b1;
      tick();
      init = 1'b0;
      tick_n(4);
      check("t5.idle", {29'd0, state_out}, 32'd2);

      // T5b: error together with drain complete
      fifo_empty = 4'b1011;
      tick();
      fifo_empty = 4'hF;
      tick_n(2);
      check("t5.drain_pre", {29'd0, state_out}, 32'd3);
      fifo_error = 4'b1000;
      tick();
      fifo_error = 4'h0;
      check("t5.drain_err", {29'd0, state_out}, 32'd4);
      check("t5.errch8", {28'd0, error_ch}, 32'h8);
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;

      // T6a: reset mid-INIT
      init = 1'b1;
      umbral_MF = 2'd3; umbral_VC = 4'd15; umbral_D = 2'd3;
      tick();
      init = 1'b0;
      tick_n(2);
      check("t6.mid_init", {29'd0, state_out}, 32'd1);
      reset = 1'b0;
      tick();
      check_all_zero("t6a");
      check("t6a.state8", {29'd0, state8}, 32'd0);
      check("t6a.state1", {29'd0, state1}, 32'd0);

      // T6b: reset mid-ACTIVE on all builds
      reset = 1'b1; init = 1'b1;
      tick();
      init = 1'b0;
      tick_n(4);
      check("t6b.idle8", {29'd0, state8}, 32'd2);
      check("t6b.idle1", {29'd0, state1}, 32'd2);
      fifo_empty = 4'b1011; fifo_empty8 = 8'h7F; fifo_empty1 = 1'b0;
      tick();
      check("t6b.act", {29'd0, state_out}, 32'd3);
      check("t6b.act8", {29'd0, state8}, 32'd3);
      check("t6b.act1", {29'd0, state1}, 32'd3);
      fifo_error8 = 8'h80;
      tick();
      fifo_error8 = 8'h00;
      check("t6b.err8", {29'd0, state8}, 32'd4);
      check("t6b.errch8", {24'd0, error_ch8}, 32'h80);
      check("t6b.act_still", {29'd0, state_out}, 32'd3);
      reset = 1'b0;
      tick();
      check_all_zero("t6b");
      check("t6b.rst8", {29'd0, state8}, 32'd0);
      check("t6b.rst_errch8", {24'd0, error_ch8}, 32'h0);
      check("t6b.rst1", {29'd0, state1}, 32'd0);
      check("t6b.rst1_flags", {28'd0, vld1, idle1, active1, error1}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
